// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - partial-sum drain: output FIFO into psum SRAM, accumulating across passes
module psum_drain #(
    parameter int psum_bw  = 16,
    parameter int col      = 8,
    parameter int len_onij = 16,
    parameter int addr_bw  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               num_pass,
    input  logic                     relu_en,
    input  logic                     ofifo_valid,
    input  logic [psum_bw*col-1:0]   ofifo_data,
    output logic                     ofifo_rd,
    output logic                     mem_cen,
    output logic                     mem_wen,
    output logic [addr_bw-1:0]       mem_addr,
    output logic [psum_bw*col-1:0]   mem_d,
    input  logic [psum_bw*col-1:0]   mem_q,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_ACC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [addr_bw-1:0] LAST_ADDR = addr_bw'(len_onij - 1);

    state_t                   r_state;
    logic [addr_bw-1:0]       r_addr;
    logic [3:0]               r_pass;
    logic [3:0]               r_last_pass;
    logic                     r_relu;
    logic [psum_bw*col-1:0]   r_hold;

    logic                     w_final;
    logic                     w_last_addr;
    logic                     w_acc;
    logic                     w_wr;
    logic [psum_bw*col-1:0]   w_wdata;

    assign w_final     = (r_pass == r_last_pass);
    assign w_last_addr = (r_addr == LAST_ADDR);
    assign w_acc       = (r_state == S_ACC);
    assign w_wr        = (r_state == S_ACC) || (r_state == S_WRITE);

    // Per-lane modulo add; mem_q is the read issued in the preceding READ cycle.
    genvar g;
    for (g = 0; g < col; g++) begin : g_lane
        logic [psum_bw-1:0] w_h;
        logic [psum_bw-1:0] w_q;
        logic [psum_bw-1:0] w_v;
        assign w_h = r_hold[g*psum_bw +: psum_bw];
        assign w_q = mem_q[g*psum_bw +: psum_bw];
        assign w_v = w_acc ? (w_h + w_q) : w_h;
        assign w_wdata[g*psum_bw +: psum_bw] =
            (r_relu && w_final && w_v[psum_bw-1]) ? '0 : w_v;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_pass      <= '0;
            r_last_pass <= '0;
            r_relu      <= 1'b0;
            r_hold      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_last_pass <= (num_pass == 4'd0) ? 4'd0 : 4'(num_pass - 4'd1);
                        r_relu      <= relu_en;
                        r_addr      <= '0;
                        r_pass      <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ofifo_valid) begin
                        r_hold  <= ofifo_data;
                        r_state <= (r_pass == 4'd0) ? S_WRITE : S_READ;
                    end
                end
                S_READ: r_state <= S_ACC;
                S_ACC, S_WRITE: begin
                    if (w_last_addr) begin
                        r_addr <= '0;
                        r_pass <= r_pass + 4'd1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                    r_state <= (w_last_addr && w_final) ? S_DONE : S_WAIT;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ofifo_rd = (r_state == S_WAIT) && ofifo_valid;
    assign mem_cen  = !((r_state == S_READ) || w_wr);
    assign mem_wen  = !w_wr;
    assign mem_addr = r_addr;
    assign mem_d    = w_wr ? w_wdata : '0;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_psum_drain.sv
// tb/tb_psum_drain.sv - directed self-checking bench for psum_drain
module tb_psum_drain;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   num_pass;
    logic         relu_en;
    logic         ofifo_valid;
    logic [127:0] ofifo_data;
    logic         ofifo_rd;
    logic         mem_cen;
    logic         mem_wen;
    logic [3:0]   mem_addr;
    logic [127:0] mem_d;
    logic [127:0] mem_q;
    logic         busy;
    logic         done;

    psum_drain dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_pass   (num_pass),
        .relu_en    (relu_en),
        .ofifo_valid(ofifo_valid),
        .ofifo_data (ofifo_data),
        .ofifo_rd   (ofifo_rd),
        .mem_cen    (mem_cen),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_d      (mem_d),
        .mem_q      (mem_q),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] rep(input logic [15:0] v);
        return {8{v}};
    endfunction

    // SRAM model: synchronous, read data appears after the read edge
    logic [127:0] sram [0:15];
    always @(posedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen) sram[mem_addr] <= mem_d;
            else          mem_q <= sram[mem_addr];
        end
    end

    // Show-ahead FIFO model
    logic [127:0] fq[$];
    logic         stall = 1'b0;
    logic         pop_pend;

    task automatic refresh();
        ofifo_valid = (fq.size() > 0) && !stall;
        ofifo_data  = (fq.size() > 0) ? fq[0] : '0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            pop_pend = ofifo_rd;
            @(posedge clk);
            #1;
            if (pop_pend && fq.size() > 0) void'(fq.pop_front());
            refresh();
        end
    end

    // Activity monitor, sampled on the falling edge
    int       n_rd, n_wr, n_rdwr, n_pop, n_busy, n_done;
    logic     prev_rd = 1'b0;
    logic [3:0] prev_addr = '0;

    always @(negedge clk) begin
        if (!mem_cen && mem_wen) n_rd++;
        if (!mem_cen && !mem_wen) begin
            n_wr++;
            if (prev_rd && prev_addr == mem_addr) n_rdwr++;
        end
        prev_rd   = !mem_cen && mem_wen;
        prev_addr = mem_addr;
        if (ofifo_rd) n_pop++;
        if (busy && !done) n_busy++;
        if (done) n_done++;
    end

    task automatic clear_stats();
        n_rd = 0; n_wr = 0; n_rdwr = 0; n_pop = 0; n_busy = 0; n_done = 0;
    endtask

    task automatic do_start(input logic [3:0] np, input logic relu);
        @(posedge clk); #1;
        start = 1'b1; num_pass = np; relu_en = relu;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        chk(tag, {127'd0, seen}, 128'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [127:0] w;
    logic [127:0] w2;
    logic         seen;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) sram[i] = '0;
        mem_q = '0;
        reset = 1'b0; start = 1'b1; num_pass = 4'd1; relu_en = 1'b0;
        fq.push_back(rep(16'h1234));
        refresh();
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ofifo_rd", {127'd0, ofifo_rd}, 128'd0);
        chk("rst_mem_cen",  {127'd0, mem_cen},  128'd1);
        chk("rst_mem_wen",  {127'd0, mem_wen},  128'd1);
        chk("rst_mem_addr", {124'd0, mem_addr}, 128'd0);
        chk("rst_mem_d",    mem_d,              128'd0);
        chk("rst_busy",     {127'd0, busy},     128'd0);
        chk("rst_done",     {127'd0, done},     128'd0);
        start = 1'b0;
        fq.delete();
        refresh();
        @(negedge clk);
        reset = 1'b1;

        // Single pass, lanes = addr+1
        for (int k = 0; k < 16; k++) fq.push_back(rep(16'(k + 1)));
        refresh();
        clear_stats();
        do_start(4'd1, 1'b0);
        wait_done("single_done", 200);
        for (int k = 0; k < 16; k++) chk($sformatf("single_addr%0d", k), sram[k], rep(16'(k + 1)));
        chk("single_done_pulses", 128'(n_done), 128'd1);
        chk("single_busy_cycles", 128'(n_busy), 128'd32);
        chk("single_writes",      128'(n_wr),   128'd16);
        chk("single_reads",       128'(n_rd),   128'd0);
        chk("single_pops",        128'(n_pop),  128'd16);
        chk("single_idle_busy",   {127'd0, busy}, 128'd0);

        // Three passes of 5 -> 15
        for (int k = 0; k < 48; k++) fq.push_back(rep(16'd5));
        refresh();
        clear_stats();
        do_start(4'd3, 1'b0);
        wait_done("acc_done", 400);
        for (int k = 0; k < 16; k++) chk($sformatf("acc_addr%0d", k), sram[k], rep(16'd15));
        chk("acc_reads",       128'(n_rd),   128'd32);
        chk("acc_writes",      128'(n_wr),   128'd48);
        chk("acc_rd_then_wr",  128'(n_rdwr), 128'd32);
        chk("acc_pops",        128'(n_pop),  128'd48);
        chk("acc_done_pulses", 128'(n_done), 128'd1);
        chk("acc_busy_cycles", 128'(n_busy), 128'd128);

        // ReLU on final pass only
        w = '0;  w[15:0] = 16'hFFF9;  w[31:16] = 16'd2;
        w2 = '0; w2[15:0] = 16'd3;    w2[31:16] = 16'd4;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 16; k++) fq.push_back(w);
            for (int k = 0; k < 16; k++) fq.push_back(w2);
            refresh();
            clear_stats();
            do_start(4'd2, (r == 0));
            wait_done($sformatf("relu%0d_done", r), 300);
            if (r == 0) begin
                chk("relu_on_addr0",  sram[0],  {96'd0, 16'd6, 16'd0});
                chk("relu_on_addr15", sram[15], {96'd0, 16'd6, 16'd0});
            end else begin
                chk("relu_off_addr0",  sram[0],  {96'd0, 16'd6, 16'hFFFC});
                chk("relu_off_addr15", sram[15], {96'd0, 16'd6, 16'hFFFC});
            end
        end

        // Overflow wrap plus a starved WAIT mid pass 1
        for (int k = 0; k < 16; k++) fq.push_back(rep(16'h7FFF));
        for (int k = 0; k < 5; k++)  fq.push_back(rep(16'h0001));
        refresh();
        clear_stats();
        do_start(4'd2, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (fq.size() == 0) begin seen = 1'b1; break; end
        end
        chk("stall_reached", {127'd0, seen}, 128'd1);
        repeat (3) @(posedge clk);
        #2;
        clear_stats();
        repeat (5) @(posedge clk);
        #2;
        chk("stall_pops",   128'(n_pop), 128'd0);
        chk("stall_reads",  128'(n_rd),  128'd0);
        chk("stall_writes", 128'(n_wr),  128'd0);
        chk("stall_busy",   {127'd0, busy}, 128'd1);
        for (int k = 0; k < 11; k++) fq.push_back(rep(16'h0001));
        refresh();
        wait_done("ovf_done", 200);
        chk("ovf_addr0",  sram[0],  rep(16'h8000));
        chk("ovf_addr15", sram[15], rep(16'h8000));

        // Reset during the pass-1 accumulate of addr 7
        for (int k = 0; k < 16; k++) fq.push_back(rep(16'd1));
        for (int k = 0; k < 16; k++) fq.push_back(rep(16'd2));
        refresh();
        clear_stats();
        do_start(4'd2, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (!mem_cen && !mem_wen && mem_addr == 4'd7 && n_wr > 16) begin seen = 1'b1; break; end
        end
        chk("mid_acc_reached", {127'd0, seen}, 128'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_mem_cen",  {127'd0, mem_cen},  128'd1);
        chk("mid_rst_mem_wen",  {127'd0, mem_wen},  128'd1);
        chk("mid_rst_mem_addr", {124'd0, mem_addr}, 128'd0);
        chk("mid_rst_mem_d",    mem_d,              128'd0);
        chk("mid_rst_busy",     {127'd0, busy},     128'd0);
        chk("mid_rst_ofifo_rd", {127'd0, ofifo_rd}, 128'd0);
        @(posedge clk); #1;
        chk("mid_rst_addr7_kept", sram[7], rep(16'd1));
        chk("mid_rst_addr6_acc",  sram[6], rep(16'd3));
        fq.delete();
        refresh();
        @(negedge clk);
        reset = 1'b1;

        // num_pass=0 runs one pass; a start while busy is ignored
        for (int k = 0; k < 16; k++) fq.push_back(rep(16'd9));
        refresh();
        clear_stats();
        do_start(4'd0, 1'b0);
        repeat (3) @(posedge clk);
        do_start(4'd3, 1'b1);
        wait_done("np0_done", 200);
        chk("np0_addr0",  sram[0],  rep(16'd9));
        chk("np0_addr7",  sram[7],  rep(16'd9));
        chk("np0_writes", 128'(n_wr),   128'd16);
        chk("np0_reads",  128'(n_rd),   128'd0);
        chk("np0_done_pulses", 128'(n_done), 128'd1);
        chk("np0_idle", {127'd0, busy}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
